// File: rtl/alu_exec_stage_p.sv
// Width-generic execute stage: operand forwarding, single-cycle ALU, iterative
// shift-add multiplier with stall, committed flag register and registered jump resolver.
module alu_exec_stage_p #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  input  logic [REG_AW-1:0] src_a_addr,
  input  logic [REG_AW-1:0] src_b_addr,
  input  logic [WIDTH-1:0]  imm,
  input  logic              alu_src,
  input  logic [REG_AW-1:0] dst_addr,
  input  logic              wb_en,
  input  logic [1:0]        jump_type,
  input  logic              flag_restore,
  input  logic [2:0]        flag_restore_data,
  input  logic              mem_fwd_en,
  input  logic [REG_AW-1:0] mem_fwd_addr,
  input  logic [WIDTH-1:0]  mem_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_addr,
  input  logic [WIDTH-1:0]  wb_fwd_data,
  output logic              busy,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic [WIDTH-1:0]  result_hi,
  output logic [WIDTH-1:0]  result_d1,
  output logic [REG_AW-1:0] out_dst,
  output logic              out_wb_en,
  output logic [WIDTH-1:0]  store_data,
  output logic [2:0]        flags,
  output logic              jump_taken
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, MUL_DONE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic [REG_AW-1:0]     mul_dst_q, mul_dst_d;
  logic                  mul_wb_q, mul_wb_d;
  logic [2:0]            flags_q, flags_d;
  logic [WIDTH-1:0]      result_q, result_d, result_hi_q, result_hi_d, result_d1_q, result_d1_d;
  logic [WIDTH-1:0]      store_data_q, store_data_d;
  logic [REG_AW-1:0]     out_dst_q, out_dst_d;
  logic                  out_wb_en_q, out_wb_en_d, out_valid_q, out_valid_d, jump_taken_q;

  logic [WIDTH-1:0]      a_op_s, b_fwd_s, b_op_s, alu_res_s;
  logic [WIDTH:0]        sum_s, step_s;
  logic [2*WIDTH-1:0]    shl_s, shr_s;
  logic                  alu_c_s, upd_c_s, upd_zn_s, ld_res_s, jsel_s, jump_taken_s;
  logic                  accept_s, is_mul_s, start_mul_s;

  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [REG_AW-1:0] addr, input logic [WIDTH-1:0] rf_val,
    input logic m_en, input logic [REG_AW-1:0] m_addr, input logic [WIDTH-1:0] m_data,
    input logic w_en, input logic [REG_AW-1:0] w_addr, input logic [WIDTH-1:0] w_data);
    logic [WIDTH-1:0] v;
    if (m_en && (m_addr == addr))      v = m_data;
    else if (w_en && (w_addr == addr)) v = w_data;
    else                               v = rf_val;
    return v;
  endfunction

  // Operand forwarding and acceptance decode
  always_comb begin
    a_op_s      = fwd_sel(src_a_addr, src_a, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                          wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    b_fwd_s     = fwd_sel(src_b_addr, src_b, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                          wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    b_op_s      = alu_src ? imm : b_fwd_s;
    accept_s    = in_valid && (state_q == IDLE);
    is_mul_s    = (op == 4'd11) && (MUL_EN != 0);
    start_mul_s = accept_s && is_mul_s;
    busy        = start_mul_s || (state_q == MUL_RUN);
  end

  // Single-cycle ALU; shifts use a double-width view so the carry is the last bit out
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = flags_q[2];
    upd_c_s   = 1'b0;
    upd_zn_s  = 1'b0;
    ld_res_s  = 1'b0;
    sum_s     = '0;
    shl_s     = {{WIDTH{1'b0}}, a_op_s} << b_op_s[3:0];
    shr_s     = {a_op_s, {WIDTH{1'b0}}} >> b_op_s[3:0];
    case (op)
      4'd1:  begin alu_res_s = a_op_s; ld_res_s = 1'b1; end
      4'd2:  begin sum_s = {1'b0, a_op_s} + {1'b0, b_op_s}; alu_res_s = sum_s[WIDTH-1:0];
                   alu_c_s = sum_s[WIDTH]; upd_c_s = 1'b1; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd3:  begin sum_s = {1'b0, a_op_s} - {1'b0, b_op_s}; alu_res_s = sum_s[WIDTH-1:0];
                   alu_c_s = sum_s[WIDTH]; upd_c_s = 1'b1; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd4:  begin alu_res_s = a_op_s & b_op_s; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd5:  begin alu_res_s = a_op_s | b_op_s; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd6:  begin alu_res_s = ~a_op_s; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd7:  begin sum_s = {1'b0, a_op_s} + ONE_X; alu_res_s = sum_s[WIDTH-1:0];
                   alu_c_s = sum_s[WIDTH]; upd_c_s = 1'b1; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd8:  begin sum_s = {1'b0, a_op_s} - ONE_X; alu_res_s = sum_s[WIDTH-1:0];
                   alu_c_s = sum_s[WIDTH]; upd_c_s = 1'b1; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd9:  begin alu_res_s = shl_s[WIDTH-1:0]; upd_c_s = (b_op_s[3:0] != 4'd0);
                   alu_c_s = shl_s[WIDTH]; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd10: begin alu_res_s = shr_s[2*WIDTH-1:WIDTH]; upd_c_s = (b_op_s[3:0] != 4'd0);
                   alu_c_s = shr_s[WIDTH-1]; upd_zn_s = 1'b1; ld_res_s = 1'b1; end
      4'd12: begin alu_res_s = b_op_s; ld_res_s = 1'b1; end
      default: begin alu_res_s = '0; ld_res_s = 1'b0; end
    endcase
  end

  // Multiplier FSM: one shift-add step per MUL_RUN cycle, LSB of prod_q is the current multiplier bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mul_dst_d = mul_dst_q;
    mul_wb_d  = mul_wb_q;
    step_s    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    case (state_q)
      IDLE: begin
        if (start_mul_s) begin
          state_d   = MUL_RUN;
          cnt_d     = CW'(WIDTH - 1);
          mcand_d   = a_op_s;
          prod_d    = {{WIDTH{1'b0}}, b_op_s};
          mul_dst_d = dst_addr;
          mul_wb_d  = wb_en;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_RUN: begin
        prod_d = {step_s, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = MUL_DONE;
        else             state_d = MUL_RUN;
      end
      MUL_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Flag commit: ALU update, then jump clear of the tested bit, then restore overrides all
  always_comb begin
    flags_d = flags_q;
    case (jump_type)
      2'd1:    jsel_s = flags_q[1];
      2'd2:    jsel_s = flags_q[0];
      2'd3:    jsel_s = flags_q[2];
      default: jsel_s = 1'b0;
    endcase
    jump_taken_s = accept_s && jsel_s;
    if (state_q == MUL_DONE) begin
      flags_d = {|prod_q[2*WIDTH-1:WIDTH], (prod_q[WIDTH-1:0] == '0), prod_q[WIDTH-1]};
    end else if (accept_s) begin
      if (!is_mul_s && upd_c_s)  flags_d[2] = alu_c_s;
      else                       flags_d[2] = flags_q[2];
      if (!is_mul_s && upd_zn_s) flags_d[1:0] = {(alu_res_s == '0), alu_res_s[WIDTH-1]};
      else                       flags_d[1:0] = flags_q[1:0];
      if (jump_taken_s) begin
        case (jump_type)
          2'd1:    flags_d[1] = 1'b0;
          2'd2:    flags_d[0] = 1'b0;
          2'd3:    flags_d[2] = 1'b0;
          default: flags_d = flags_d;
        endcase
      end else begin
        flags_d = flags_d;
      end
      if (flag_restore) flags_d = flag_restore_data;
      else              flags_d = flags_d;
    end else begin
      flags_d = flags_q;
    end
  end

  // Result and destination registers' next values
  always_comb begin
    result_d     = result_q;
    result_hi_d  = result_hi_q;
    result_d1_d  = result_d1_q;
    store_data_d = store_data_q;
    out_dst_d    = out_dst_q;
    out_wb_en_d  = 1'b0;
    out_valid_d  = 1'b0;
    if (state_q == MUL_DONE) begin
      out_valid_d = 1'b1;
      result_d    = prod_q[WIDTH-1:0];
      result_hi_d = prod_q[2*WIDTH-1:WIDTH];
      result_d1_d = result_q;
      out_dst_d   = mul_dst_q;
      out_wb_en_d = mul_wb_q;
    end else if (accept_s) begin
      store_data_d = b_fwd_s;
      if (!is_mul_s) begin
        out_valid_d = 1'b1;
        out_dst_d   = dst_addr;
        out_wb_en_d = wb_en;
        if (ld_res_s) begin
          result_d    = alu_res_s;
          result_hi_d = '0;
          result_d1_d = result_q;
        end else begin
          result_d = result_q;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      mul_dst_q    <= '0;
      mul_wb_q     <= 1'b0;
      flags_q      <= 3'b000;
      result_q     <= '0;
      result_hi_q  <= '0;
      result_d1_q  <= '0;
      store_data_q <= '0;
      out_dst_q    <= '0;
      out_wb_en_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      jump_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      prod_q       <= prod_d;
      mul_dst_q    <= mul_dst_d;
      mul_wb_q     <= mul_wb_d;
      flags_q      <= flags_d;
      result_q     <= result_d;
      result_hi_q  <= result_hi_d;
      result_d1_q  <= result_d1_d;
      store_data_q <= store_data_d;
      out_dst_q    <= out_dst_d;
      out_wb_en_q  <= out_wb_en_d;
      out_valid_q  <= out_valid_d;
      jump_taken_q <= jump_taken_s;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign result_d1  = result_d1_q;
  assign out_dst    = out_dst_q;
  assign out_wb_en  = out_wb_en_q;
  assign store_data = store_data_q;
  assign flags      = flags_q;
  assign jump_taken = jump_taken_q;

endmodule

// File: tb/tb_alu_exec_stage_p.sv
// Directed bench for alu_exec_stage_p (WIDTH=16) with hand-computed expected values.
module tb_alu_exec_stage_p;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, alu_src, wb_en, flag_restore;
  logic [3:0]    op;
  logic [W-1:0]  src_a, src_b, imm, mem_fwd_data, wb_fwd_data;
  logic [AW-1:0] src_a_addr, src_b_addr, dst_addr, mem_fwd_addr, wb_fwd_addr;
  logic [1:0]    jump_type;
  logic [2:0]    flag_restore_data;
  logic          mem_fwd_en, wb_fwd_en;
  logic          busy, out_valid, out_wb_en, jump_taken;
  logic [W-1:0]  result, result_hi, result_d1, store_data;
  logic [AW-1:0] out_dst;
  logic [2:0]    flags;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage_p #(.WIDTH(W), .REG_AW(AW), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .imm(imm), .alu_src(alu_src),
    .dst_addr(dst_addr), .wb_en(wb_en), .jump_type(jump_type), .flag_restore(flag_restore),
    .flag_restore_data(flag_restore_data), .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr),
    .wb_fwd_data(wb_fwd_data), .busy(busy), .out_valid(out_valid), .result(result),
    .result_hi(result_hi), .result_d1(result_d1), .out_dst(out_dst), .out_wb_en(out_wb_en),
    .store_data(store_data), .flags(flags), .jump_taken(jump_taken)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0; imm = '0; alu_src = 1'b0;
    src_a_addr = '0; src_b_addr = '0; dst_addr = '0; wb_en = 1'b0; jump_type = 2'd0;
    flag_restore = 1'b0; flag_restore_data = 3'b000;
    mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
    wb_fwd_en = 1'b0; wb_fwd_addr = '0; wb_fwd_data = '0;
  endtask

  // Present one instruction for a single cycle; outputs are sampled #1 after the accepting edge
  task automatic exec(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic asrc, input logic [W-1:0] im, input logic [1:0] jt);
    in_valid = 1'b1; op = o; src_a = a; src_b = b; alu_src = asrc; imm = im; jump_type = jt;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic [2:0] f, input logic [W-1:0] d1);
    int cyc;
    in_valid = 1'b1; op = 4'd11; src_a = a; src_b = b; dst_addr = 3'd5; wb_en = 1'b1;
    #1 chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 4'd2; src_a = 16'h1111; src_b = 16'h2222; dst_addr = 3'd1;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
    clear_inputs();
    chk({tag, "_busy_cycles"}, cyc, 32'd16);
    chk({tag, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_lo"}, {16'd0, result}, {16'd0, lo});
    chk({tag, "_hi"}, {16'd0, result_hi}, {16'd0, hi});
    chk({tag, "_flags"}, {29'd0, flags}, {29'd0, f});
    chk({tag, "_d1"}, {16'd0, result_d1}, {16'd0, d1});
    chk({tag, "_dst"}, {29'd0, out_dst}, 32'd5);
  endtask

  initial begin
    int seen;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_hi", {16'd0, result_hi}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    chk("rst_jump", {31'd0, jump_taken}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    dst_addr = 3'd2; wb_en = 1'b1;
    exec(4'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 2'd0);
    chk("add_res", {16'd0, result}, 32'h0000);
    chk("add_flags", {29'd0, flags}, 32'b110);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_dst", {29'd0, out_dst}, 32'd2);
    chk("add_wben", {31'd0, out_wb_en}, 32'd1);
    chk("add_store", {16'd0, store_data}, 32'h0001);
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    src_a_addr = 3'd3; mem_fwd_en = 1'b1; mem_fwd_addr = 3'd3; mem_fwd_data = 16'h0010;
    wb_fwd_en = 1'b1; wb_fwd_addr = 3'd3; wb_fwd_data = 16'h0020;
    exec(4'd1, 16'h0005, 16'h0000, 1'b0, 16'h0000, 2'd0);
    chk("fwd_mem", {16'd0, result}, 32'h0010);
    chk("mov_flags", {29'd0, flags}, 32'b110);

    src_b_addr = 3'd4; mem_fwd_en = 1'b1; mem_fwd_addr = 3'd3; mem_fwd_data = 16'h0010;
    wb_fwd_en = 1'b1; wb_fwd_addr = 3'd4; wb_fwd_data = 16'h0020;
    exec(4'd12, 16'h0000, 16'h0009, 1'b0, 16'h0000, 2'd0);
    chk("fwd_wb", {16'd0, result}, 32'h0020);
    chk("fwd_wb_store", {16'd0, store_data}, 32'h0020);
    chk("res_d1", {16'd0, result_d1}, 32'h0010);

    exec(4'd12, 16'h0000, 16'h0007, 1'b1, 16'h1234, 2'd0);
    chk("imm_res", {16'd0, result}, 32'h1234);
    chk("imm_store", {16'd0, store_data}, 32'h0007);

    exec(4'd5, 16'h8000, 16'h0001, 1'b0, 16'h0000, 2'd0);
    chk("or_res", {16'd0, result}, 32'h8001);
    chk("or_flags", {29'd0, flags}, 32'b101);

    exec(4'd3, 16'h0005, 16'h0005, 1'b0, 16'h0000, 2'd0);
    chk("sub_eq_flags", {29'd0, flags}, 32'b010);
    exec(4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd1);
    chk("jz_taken", {31'd0, jump_taken}, 32'd1);
    chk("jz_clear", {29'd0, flags}, 32'b000);
    exec(4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd2);
    chk("jn_not_taken", {31'd0, jump_taken}, 32'd0);
    chk("jn_flags", {29'd0, flags}, 32'b000);

    exec(4'd3, 16'h0003, 16'h0005, 1'b0, 16'h0000, 2'd0);
    chk("sub_borrow_res", {16'd0, result}, 32'hFFFE);
    chk("sub_borrow_flags", {29'd0, flags}, 32'b101);
    exec(4'd9, 16'h8001, 16'h0001, 1'b0, 16'h0000, 2'd0);
    chk("shl_res", {16'd0, result}, 32'h0002);
    chk("shl_flags", {29'd0, flags}, 32'b100);
    exec(4'd10, 16'h0002, 16'hAAAA, 1'b1, 16'h0001, 2'd0);
    chk("shr_res", {16'd0, result}, 32'h0001);
    chk("shr_flags", {29'd0, flags}, 32'b000);
    exec(4'd8, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0);
    chk("dec_res", {16'd0, result}, 32'hFFFF);
    chk("dec_flags", {29'd0, flags}, 32'b101);
    exec(4'd7, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 2'd0);
    chk("inc_res", {16'd0, result}, 32'h0000);
    chk("inc_flags", {29'd0, flags}, 32'b110);
    exec(4'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd1);
    chk("jz_vs_alu_taken", {31'd0, jump_taken}, 32'd1);
    chk("jz_vs_alu_flags", {29'd0, flags}, 32'b000);
    exec(4'd6, 16'h00FF, 16'h0000, 1'b0, 16'h0000, 2'd0);
    chk("not_res", {16'd0, result}, 32'hFF00);
    chk("not_flags", {29'd0, flags}, 32'b001);

    flag_restore = 1'b1; flag_restore_data = 3'b101;
    exec(4'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0);
    chk("restore_flags", {29'd0, flags}, 32'b101);

    run_mul("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b100, 16'h0000);
    run_mul("mul_tp", 16'h0100, 16'h0300, 16'h0000, 16'h0003, 3'b110, 16'h0001);
    exec(4'd2, 16'h0002, 16'h0003, 1'b0, 16'h0000, 2'd0);
    chk("post_mul_res", {16'd0, result}, 32'h0005);
    chk("post_mul_hi", {16'd0, result_hi}, 32'h0000);

    in_valid = 1'b1; op = 4'd11; src_a = 16'h0100; src_b = 16'h0300;
    @(posedge clk); #1;
    clear_inputs();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_flags", {29'd0, flags}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 32'd0);
    exec(4'd2, 16'h0002, 16'h0003, 1'b0, 16'h0000, 2'd0);
    chk("after_abort_add", {16'd0, result}, 32'h0005);
    chk("after_abort_valid", {31'd0, out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage_p.md
Name: alu_exec_stage_p

Overview:
Parametrised execute stage for the pipelined processor. It replaces the fixed 16-bit ALU stage with a width-generic stage and adds:
- an internal operand-forwarding mux;
- a multi-cycle iterative multiplier with pipeline stall;
- a flag register with restore from memory;
- a registered conditional-jump resolver.
It sits between the decode/register-read buffer and the memory stage.

Parameters:
- WIDTH, 16, datapath width in bits (even, ≥4)
- REG_AW, 3, register-file address width
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL executes as NOP

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present in the decode buffer
- op  in  4  ALU opcode (see Behaviour)
- src_a  in  WIDTH  register-file operand A
- src_b  in  WIDTH  register-file operand B
- src_a_addr, src_b_addr  in  REG_AW  operand register numbers
- imm  in  WIDTH  immediate value
- alu_src  in  1  1 = B operand is imm
- dst_addr  in  REG_AW  destination register
- wb_en  in  1  instruction writes a register
- jump_type  in  2  0 none, 1 JZ, 2 JN, 3 JC
- flag_restore  in  1  load flags from memory (RTI)
- flag_restore_data  in  3  {C,Z,N} from data memory
- mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1/REG_AW/WIDTH  memory-stage writeback candidate
- wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1/REG_AW/WIDTH  writeback-stage candidate
- busy  out  1  stall request to fetch/decode
- out_valid  out  1  result valid this cycle
- result  out  WIDTH  registered result (low half for MUL)
- result_hi  out  WIDTH  high half of MUL product, 0 otherwise
- result_d1  out  WIDTH  result delayed one further accepted cycle
- out_dst, out_wb_en  out  REG_AW/1  registered destination info
- store_data  out  WIDTH  forwarded B operand, pre-immediate
- flags  out  3  committed {C,Z,N}
- jump_taken  out  1  registered jump decision

Behaviour:
- Reset (rst_n=0, async): all outputs and the flag register are 0; FSM enters IDLE.
- Forwarding, per operand:
  - mem_fwd wins when mem_fwd_en and the address matches.
  - Otherwise wb_fwd wins when wb_fwd_en and the address matches.
  - Otherwise the register-file value is used.
  - The B operand is then muxed with imm when alu_src=1.
- Opcodes; B means the effective B operand:
  - 0 NOP
  - 1 MOV = A
  - 2 ADD
  - 3 SUB (A-B)
  - 4 AND
  - 5 OR
  - 6 NOT A
  - 7 INC A
  - 8 DEC A
  - 9 SHL A by B[3:0]
  - 10 SHR A by B[3:0] (logical)
  - 11 MUL
  - 12 PASS B
  - 13-15 NOP
- Flags:
  - C = carry-out for ADD/INC, borrow for SUB/DEC, last bit shifted out for shifts, |result_hi for MUL.
  - Z = low result == 0.
  - N = MSB of the low result.
  - NOP/MOV/PASS leave flags unchanged; logic ops update Z and N and keep C.
- Single-cycle ops: an op accepted at edge k has result, out_valid and flags updated at edge k+1.
- out_valid = 0 when in_valid = 0, and while busy except the completion cycle.
- result_d1 loads the old result whenever result loads.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE + in_valid + op=11 → MUL_RUN. Operands are latched, counter = WIDTH-1, busy=1 combinationally in the same cycle.
  - MUL_RUN: one shift-add step per cycle; at counter 0 → MUL_DONE.
  - MUL_DONE: result/result_hi/flags are written, out_valid=1, busy=0, → IDLE.
  - Total MUL latency is WIDTH+1 cycles from acceptance to out_valid.
  - Inputs are ignored while in MUL_RUN.
- flag_restore=1 overrides the computed flags with flag_restore_data, same cycle, highest priority.
- Jump resolution:
  - jump_taken at edge k+1 = jump_type selects Z, N or C from the flags value *before* edge k+1 (the committed flags).
  - When taken, the tested flag bit is cleared at edge k+1; this has priority over an ALU update to that bit only.
- Reset asserted during MUL_RUN aborts the multiply: busy drops immediately and no out_valid is produced.

Test Plan:
- ADD, WIDTH=16, A=0xFFFF, B=0x0001, alu_src=0 → result=0x0000, flags C=1 Z=1 N=0, out_valid one cycle later.
- Forwarding: src_a_addr=3, mem_fwd {en=1, addr=3, data=0x0010}, wb_fwd {en=1, addr=3, data=0x0020}, src_a=0x0005, MOV → result=0x0010.
- MUL 0x0100 × 0x0300 → busy high for 16 cycles; at cycle 17 result=0x0000, result_hi=0x0003, C=1, Z=1; any inputs during the run are ignored.
- JZ after a SUB 5-5 → jump_taken=1 on the next edge and Z cleared. JN with N=0 → jump_taken=0 and flags unchanged.
- flag_restore=1 with data 3'b101 concurrent with an ADD producing flags 3'b010 → flags=3'b101.
- Async reset pulsed mid-MUL (cycle 6) → busy, out_valid, result and flags go to 0 immediately. A subsequent ADD 2+3 gives 5 one cycle after acceptance.
